// File: rtl/cdb_arbiter_pkg.sv
// Shared common-data-bus definitions: tag/data widths, the idle tag and the
// fixed assignment of execution units to arbiter source slots.
package cdb_arbiter_pkg;

    localparam int             CDB_NUM_SRC     = 4;
    localparam int             CDB_ROB_W       = 6;
    localparam int             CDB_DATA_W      = 32;
    localparam int             CDB_DEPTH       = 2;
    localparam logic [5:0]     CDB_INVALID_ROB = 6'b010000;

    // Which execution unit drives which source slot of the arbiter.
    typedef enum logic [1:0] {
        SRC_ADD   = 2'd0,
        SRC_MUL   = 2'd1,
        SRC_LOAD  = 2'd2,
        SRC_STORE = 2'd3
    } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source result FIFO: DEPTH entries of {rob, data}. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
// Push and pop on the same edge are legal at any occupancy; the owner never
// pops an empty FIFO.
module cdb_arbiter_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int WIDTH = CDB_ROB_W + CDB_DATA_W,
    parameter int DEPTH = CDB_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointer next-state: flush empties the FIFO, otherwise advance on push/pop.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset discards any queued results immediately.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage write port.
    // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: queues result broadcasts from the execution units
// in per-source FIFOs and grants up to two of them per cycle, round-robin,
// onto two registered CDB channels. Channel 2 is only used when channel 1 is.
// Optional feature macro: CDB_BYPASS_EN -- a result arriving at an empty FIFO
// may win arbitration in its arrival cycle and skip the FIFO (latency 1
// instead of 2).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int               NUM_SRC     = CDB_NUM_SRC,
    parameter int               ROB_W       = CDB_ROB_W,
    parameter int               DATA_W      = CDB_DATA_W,
    parameter int               DEPTH       = CDB_DEPTH,
    parameter logic [ROB_W-1:0] INVALID_ROB = CDB_INVALID_ROB
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*ROB_W-1:0]  src_rob,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      CDBiscast,
    output logic [ROB_W-1:0]          CDBrobNum,
    output logic [DATA_W-1:0]         CDBdata,
    output logic                      CDBiscast2,
    output logic [ROB_W-1:0]          CDBrobNum2,
    output logic [DATA_W-1:0]         CDBdata2,
    output logic                      overflow
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int EW = ROB_W + DATA_W;

    logic [NUM_SRC-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [NUM_SRC-1:0] eligible, granted, bypass_win, ready;
    logic [EW-1:0]      src_entry  [NUM_SRC];
    logic [EW-1:0]      fifo_head  [NUM_SRC];
    logic [EW-1:0]      cand_entry [NUM_SRC];

    logic               gnt1_vld, gnt2_vld;
    logic [IW-1:0]      gnt1_idx, gnt2_idx;

    logic               cdb1_vld_q, cdb1_vld_d, cdb2_vld_q, cdb2_vld_d;
    logic [ROB_W-1:0]   cdb1_rob_q, cdb1_rob_d, cdb2_rob_q, cdb2_rob_d;
    logic [DATA_W-1:0]  cdb1_data_q, cdb1_data_d, cdb2_data_q, cdb2_data_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               overflow_q, overflow_d;

    // Round-robin successor of a source index.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        int n;
        n = int'(idx) + 1;
        if (n >= NUM_SRC) n = 0;
        return IW'(n);
    endfunction

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign src_entry[k] = {src_rob[k*ROB_W +: ROB_W], src_data[k*DATA_W +: DATA_W]};

        cdb_arbiter_src_fifo #(
            .WIDTH (EW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .flush_i (flush),
            .push_i  (fifo_push[k]),
            .data_i  (src_entry[k]),
            .pop_i   (fifo_pop[k]),
            .full_o  (fifo_full[k]),
            .empty_o (fifo_empty[k]),
            .head_o  (fifo_head[k])
        );
    end

    // Per-source eligibility and the entry it would broadcast if granted.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
`ifdef CDB_BYPASS_EN
            eligible[k]   = !flush && (!fifo_empty[k] || src_valid[k]);
            cand_entry[k] = fifo_empty[k] ? src_entry[k] : fifo_head[k];
`else
            eligible[k]   = !flush && !fifo_empty[k];
            cand_entry[k] = fifo_head[k];
`endif
        end
    end

    // Two-grant picker: scan upward from rr_ptr; first hit is channel 1, second channel 2.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_w;
        idx      = 0;
        idx_w    = '0;
        gnt1_vld = 1'b0;
        gnt2_vld = 1'b0;
        gnt1_idx = '0;
        gnt2_idx = '0;
        granted  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            idx_w = IW'(idx);
            if (eligible[idx_w]) begin
                if (!gnt1_vld) begin
                    gnt1_vld = 1'b1;
                    gnt1_idx = idx_w;
                    granted[idx_w] = 1'b1;
                end else if (!gnt2_vld) begin
                    gnt2_vld = 1'b1;
                    gnt2_idx = idx_w;
                    granted[idx_w] = 1'b1;
                end
            end
        end
    end

    // FIFO control: granted queued entries pop; accepted, non-bypassed pulses push.
    always_comb begin
        bypass_win = granted & fifo_empty;
        fifo_pop   = granted & ~fifo_empty;
`ifdef CDB_BYPASS_EN
        ready      = ~fifo_full | fifo_pop;
`else
        ready      = ~fifo_full;
`endif
        fifo_push  = src_valid & ready & ~bypass_win & {NUM_SRC{!flush}};
    end

    // Next state of the channel registers, round-robin pointer and overflow flag.
    always_comb begin
        cdb1_vld_d  = gnt1_vld;
        cdb1_rob_d  = INVALID_ROB;
        cdb1_data_d = '0;
        cdb2_vld_d  = gnt2_vld;
        cdb2_rob_d  = INVALID_ROB;
        cdb2_data_d = '0;
        if (gnt1_vld) {cdb1_rob_d, cdb1_data_d} = cand_entry[gnt1_idx];
        if (gnt2_vld) {cdb2_rob_d, cdb2_data_d} = cand_entry[gnt2_idx];

        rr_ptr_d = rr_ptr_q;
        if (flush)         rr_ptr_d = '0;
        else if (gnt2_vld) rr_ptr_d = next_idx(gnt2_idx);
        else if (gnt1_vld) rr_ptr_d = next_idx(gnt1_idx);

        // A pulse in a flush cycle is discarded, not counted as a lost result.
        overflow_d = overflow_q | (|(src_valid & ~ready & {NUM_SRC{!flush}}));
    end

    // Registered CDB channels, round-robin pointer and sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb1_vld_q  <= 1'b0;
            cdb1_rob_q  <= INVALID_ROB;
            cdb1_data_q <= '0;
            cdb2_vld_q  <= 1'b0;
            cdb2_rob_q  <= INVALID_ROB;
            cdb2_data_q <= '0;
            rr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            cdb1_vld_q  <= cdb1_vld_d;
            cdb1_rob_q  <= cdb1_rob_d;
            cdb1_data_q <= cdb1_data_d;
            cdb2_vld_q  <= cdb2_vld_d;
            cdb2_rob_q  <= cdb2_rob_d;
            cdb2_data_q <= cdb2_data_d;
            rr_ptr_q    <= rr_ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    assign src_ready  = ready;
    assign CDBiscast  = cdb1_vld_q;
    assign CDBrobNum  = cdb1_rob_q;
    assign CDBdata    = cdb1_data_q;
    assign CDBiscast2 = cdb2_vld_q;
    assign CDBrobNum2 = cdb2_rob_q;
    assign CDBdata2   = cdb2_data_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, three-way grant and
// round-robin continuation, back-pressure/overflow, flush, fairness, and
// reset while results are queued. Build with CDB_BYPASS_EN for latency 1.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic         clock, reset, flush;
    logic [3:0]   src_valid;
    logic [23:0]  src_rob;
    logic [127:0] src_data;
    logic [3:0]   src_ready;
    logic         CDBiscast, CDBiscast2, overflow;
    logic [5:0]   CDBrobNum, CDBrobNum2;
    logic [31:0]  CDBdata, CDBdata2;

    int         n_pass    = 0;
    int         n_total   = 0;
    int         fill_viol = 0;
    bit         mon_en    = 1'b0;
    logic [5:0] seen1[$];

    cdb_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_rob    (src_rob),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .CDBiscast  (CDBiscast),
        .CDBrobNum  (CDBrobNum),
        .CDBdata    (CDBdata),
        .CDBiscast2 (CDBiscast2),
        .CDBrobNum2 (CDBrobNum2),
        .CDBdata2   (CDBdata2),
        .overflow   (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Channel monitor: fill-order violations and src1 tags (tags below 16) in broadcast order.
    always @(negedge clock) begin
        if (reset && CDBiscast2 && !CDBiscast) fill_viol++;
        if (mon_en) begin
            if (CDBiscast  && CDBrobNum  < 6'd16) seen1.push_back(CDBrobNum);
            if (CDBiscast2 && CDBrobNum2 < 6'd16) seen1.push_back(CDBrobNum2);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [5:0] rob, input logic [31:0] data);
        src_valid[k]          = v;
        src_rob[k*6 +: 6]     = rob;
        src_data[k*32 +: 32]  = data;
    endtask

    task automatic do_reset();
        src_valid = '0;
        flush     = 1'b0;
        reset     = 1'b0;
        #2;
        reset     = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        flush     = 1'b0;
        src_valid = 4'b1111;
        src_rob   = {6'd4, 6'd3, 6'd2, 6'd1};
        src_data  = '1;
        tick();
        tick();
        n_total++;
        if (CDBiscast !== 1'b0) $display("FAIL reset_valid1: got %0b want 0", CDBiscast); else n_pass++;
        n_total++;
        if (CDBiscast2 !== 1'b0) $display("FAIL reset_valid2: got %0b want 0", CDBiscast2); else n_pass++;
        n_total++;
        if (CDBrobNum !== 6'd16 || CDBrobNum2 !== 6'd16)
            $display("FAIL reset_rob: got %0d/%0d want 16/16", CDBrobNum, CDBrobNum2);
        else n_pass++;
        n_total++;
        if (CDBdata !== 32'd0 || CDBdata2 !== 32'd0)
            $display("FAIL reset_data: got %h/%h want 0/0", CDBdata, CDBdata2);
        else n_pass++;
        n_total++;
        if (src_ready !== 4'b1111) $display("FAIL reset_ready: got %b want 1111", src_ready); else n_pass++;
        n_total++;
        if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", overflow); else n_pass++;
        src_valid = '0;
        reset     = 1'b1;
        tick();
    endtask

    task automatic test_single_source();
        do_reset();
        drive(SRC_ADD, 1'b1, 6'd3, 32'h2A);
        tick();
        drive(SRC_ADD, 1'b0, 6'd0, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            n_total++;
            if (CDBiscast !== (c == LAT))
                $display("FAIL single_valid c=%0d: got %0b want %0b", c, CDBiscast, (c == LAT));
            else n_pass++;
            n_total++;
            if (CDBiscast2 !== 1'b0) $display("FAIL single_ch2 c=%0d: got %0b want 0", c, CDBiscast2); else n_pass++;
            if (c == LAT) begin
                n_total++;
                if (CDBrobNum !== 6'd3 || CDBdata !== 32'h2A)
                    $display("FAIL single_payload: got rob=%0d data=%h want rob=3 data=2a", CDBrobNum, CDBdata);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_three_sources();
        logic       ev1, ev2;
        logic [5:0] er1, er2;
        do_reset();
        drive(SRC_ADD,  1'b1, 6'd5, 32'h105);
        drive(SRC_MUL,  1'b1, 6'd6, 32'h106);
        drive(SRC_LOAD, 1'b1, 6'd7, 32'h107);
        tick();
        src_valid = '0;
        for (int c = 1; c <= LAT + 2; c++) begin
            ev1 = (c == LAT) || (c == LAT + 1);
            er1 = (c == LAT) ? 6'd5 : ((c == LAT + 1) ? 6'd7 : 6'd16);
            ev2 = (c == LAT);
            er2 = (c == LAT) ? 6'd6 : 6'd16;
            n_total++;
            if ({CDBiscast, CDBrobNum} !== {ev1, er1})
                $display("FAIL three_ch1 c=%0d: got v=%0b rob=%0d want v=%0b rob=%0d", c, CDBiscast, CDBrobNum, ev1, er1);
            else n_pass++;
            n_total++;
            if ({CDBiscast2, CDBrobNum2} !== {ev2, er2})
                $display("FAIL three_ch2 c=%0d: got v=%0b rob=%0d want v=%0b rob=%0d", c, CDBiscast2, CDBrobNum2, ev2, er2);
            else n_pass++;
            if (c == LAT) begin
                n_total++;
                if (CDBdata !== 32'h105 || CDBdata2 !== 32'h106)
                    $display("FAIL three_data1: got %h/%h want 105/106", CDBdata, CDBdata2);
                else n_pass++;
            end
            if (c == LAT + 1) begin
                n_total++;
                if (CDBdata !== 32'h107 || CDBdata2 !== 32'h0)
                    $display("FAIL three_data2: got %h/%h want 107/0", CDBdata, CDBdata2);
                else n_pass++;
            end
            tick();
        end
        // rr_ptr now 3: source 3 must take channel 1 ahead of source 0.
        drive(SRC_ADD,   1'b1, 6'd8, 32'h108);
        drive(SRC_STORE, 1'b1, 6'd9, 32'h109);
        tick();
        src_valid = '0;
        for (int c = 1; c < LAT; c++) tick();
        n_total++;
        if ({CDBiscast, CDBrobNum, CDBiscast2, CDBrobNum2} !== {1'b1, 6'd9, 1'b1, 6'd8})
            $display("FAIL rr_continue: got %0b/%0d %0b/%0d want 1/9 1/8", CDBiscast, CDBrobNum, CDBiscast2, CDBrobNum2);
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_back_pressure();
        logic [5:0] acc[$];
        int         seq0 = 0, seq1 = 1, seq2 = 0, n_bad = 0;
        bit         dropped = 1'b0;
        do_reset();
        seen1.delete();
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 12 && !dropped; cyc++) begin
            if (!src_ready[1]) begin
                dropped = 1'b1;
            end else begin
                drive(SRC_ADD, src_ready[0], 6'(32 + seq0 % 16), 32'(seq0));
                if (src_ready[0]) seq0++;
                drive(SRC_LOAD, src_ready[2], 6'(48 + seq2 % 16), 32'(seq2));
                if (src_ready[2]) seq2++;
                drive(SRC_MUL, 1'b1, 6'(seq1), 32'(1000 + seq1));
                acc.push_back(6'(seq1));
                seq1++;
                tick();
            end
        end
        n_total++;
        if (!dropped) $display("FAIL bp_ready_drop: src_ready[1] stayed 1 for 12 cycles, want 0"); else n_pass++;
        n_total++;
        if (acc.size() - seen1.size() != 2)
            $display("FAIL bp_depth: queued at drop got %0d want 2", acc.size() - seen1.size());
        else n_pass++;
        n_total++;
        if (overflow !== 1'b0) $display("FAIL bp_overflow_pre: got %0b want 0", overflow); else n_pass++;
        src_valid = '0;
        drive(SRC_MUL, 1'b1, 6'd15, 32'hDEAD);
        tick();
        src_valid = '0;
        n_total++;
        if (overflow !== 1'b1) $display("FAIL bp_overflow_set: got %0b want 1", overflow); else n_pass++;
        for (int c = 0; c < 12; c++) tick();
        mon_en = 1'b0;
        n_total++;
        if (seen1.size() != acc.size())
            $display("FAIL bp_drain_count: got %0d src1 results want %0d", seen1.size(), acc.size());
        else n_pass++;
        for (int i = 0; i < acc.size() && i < seen1.size(); i++)
            if (seen1[i] !== acc[i]) n_bad++;
        n_total++;
        if (n_bad != 0) $display("FAIL bp_drain_order: got %0d out-of-order entries want 0", n_bad); else n_pass++;
        n_total++;
        if (overflow !== 1'b1) $display("FAIL bp_overflow_sticky: got %0b want 1", overflow); else n_pass++;
    endtask

    task automatic test_flush();
        logic ov_before;
        ov_before = overflow;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(SRC_ADD,   1'b1, 6'h21, 32'h21);
        drive(SRC_MUL,   1'b1, 6'h22, 32'h22);
        drive(SRC_LOAD,  1'b1, 6'h23, 32'h23);
        drive(SRC_STORE, 1'b1, 6'h24, 32'h24);
        tick();
        src_valid = '0;
        drive(SRC_LOAD, 1'b1, 6'h25, 32'h25);
        tick();
        src_valid = '0;
        n_total++;
        if (CDBiscast !== 1'b1) $display("FAIL flush_busy_before: got %0b want 1", CDBiscast); else n_pass++;
        flush = 1'b1;
        drive(SRC_ADD, 1'b1, 6'h27, 32'h27);
        tick();
        flush     = 1'b0;
        src_valid = '0;
        n_total++;
        if (src_ready !== 4'b1111) $display("FAIL flush_ready: got %b want 1111", src_ready); else n_pass++;
        n_total++;
        if (CDBrobNum !== 6'd16 || CDBrobNum2 !== 6'd16)
            $display("FAIL flush_rob: got %0d/%0d want 16/16", CDBrobNum, CDBrobNum2);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_total++;
            if (CDBiscast !== 1'b0 || CDBiscast2 !== 1'b0)
                $display("FAIL flush_idle c=%0d: got %0b/%0b want 0/0", c, CDBiscast, CDBiscast2);
            else n_pass++;
            tick();
        end
        n_total++;
        if (overflow !== ov_before) $display("FAIL flush_overflow: got %0b want %0b", overflow, ov_before); else n_pass++;
    endtask

    task automatic test_fairness();
        int seq[4];
        int cnt[4];
        do_reset();
        for (int k = 0; k < 4; k++) begin
            seq[k] = 0;
            cnt[k] = 0;
        end
        for (int t = 1; t <= 20; t++) begin
            for (int k = 0; k < 4; k++) begin
                drive(k, src_ready[k], 6'(k * 16 + 1 + seq[k] % 15), 32'(seq[k]));
                if (src_ready[k]) seq[k]++;
            end
            tick();
            if (t >= 8 && t < 16) begin
                if (CDBiscast)  cnt[CDBrobNum[5:4]]++;
                if (CDBiscast2) cnt[CDBrobNum2[5:4]]++;
            end
        end
        src_valid = '0;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (cnt[k] != 4) $display("FAIL fair_src%0d: got %0d grants want 4", k, cnt[k]); else n_pass++;
        end
        n_total++;
        if (overflow !== 1'b0) $display("FAIL fair_overflow: got %0b want 0", overflow); else n_pass++;
    endtask

    task automatic test_reset_mid();
        // Queues are still loaded from the fairness run.
        reset = 1'b0;
        #1;
        n_total++;
        if (CDBiscast !== 1'b0 || CDBrobNum !== 6'd16)
            $display("FAIL rstmid_async: got v=%0b rob=%0d want v=0 rob=16", CDBiscast, CDBrobNum);
        else n_pass++;
        #2;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (CDBiscast !== 1'b0 || CDBiscast2 !== 1'b0)
                $display("FAIL rstmid_idle c=%0d: got %0b/%0b want 0/0", c, CDBiscast, CDBiscast2);
            else n_pass++;
        end
        n_total++;
        if (fill_viol != 0) $display("FAIL fill_order: got %0d cycles with ch2 valid and ch1 idle want 0", fill_viol);
        else n_pass++;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        src_valid = '0;
        src_rob   = '0;
        src_data  = '0;
        test_reset();
        test_single_source();
        test_three_sources();
        test_back_pressure();
        test_flush();
        test_fairness();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
